// File: rtl/ramdisk_ptr_ctrl.sv
// Apple II slot RAM-disk controller: NPTR auto-stepping SRAM address pointers,
// a data port through the selected pointer, and a ROM bank bit, timed off a PHI1-synced 7M counter.

module ramdisk_ptr_lane #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [1:0]        bsel,
  input  logic [7:0]        din,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);
  logic [23:0] ext, nxt;

  // Byte writes go through a 24-bit view; bits above ADDR_W are dropped.
  always_comb begin
    ext = '0;
    ext[ADDR_W-1:0] = ptr;
    nxt = ext;
    case (bsel)
      2'd0:    nxt[7:0]   = din;
      2'd1:    nxt[15:8]  = din;
      default: nxt[23:16] = din;
    endcase
  end

  assign wrap = step & (dir ? (ptr == '0) : (&ptr));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    ptr <= '0;
    else if (step) ptr <= dir ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
    else if (wr)   ptr <= nxt[ADDR_W-1:0];
endmodule

module ramdisk_ptr_ctrl #(
  parameter int ADDR_W = 24,
  parameter int NPTR   = 2
) (
  input  logic              C7M,
  input  logic              nRES,
  input  logic              PHI1,
  input  logic [3:0]        A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic [7:0]        Din,
  input  logic [7:0]        RD,
  output logic [7:0]        Dout,
  output logic              DOE,
  output logic              RDOE,
  output logic              RAMCS,
  output logic [ADDR_W-1:0] RA,
  output logic              Bank
);
  logic                       phi1_reg, phi0_seen, regen, dben, csen;
  logic                       pend, pdir, bank_q;
  logic [2:0]                 s, s_nxt;
  logic [3:0]                 ctrl;
  logic [1:0]                 p, pidx;
  logic [NPTR-1:0]            wrap, wrap_set;
  logic [NPTR-1:0][ADDR_W-1:0] ptrs;
  logic                       reg_sel, data_sel, wr6, ptr_wr, step1, stat_clr;
  logic [23:0]                rext;
  logic [7:0]                 st;

  assign p = ctrl[1:0] & 2'(NPTR-1);

  always_comb begin
    if (PHI1 && !phi1_reg && phi0_seen) s_nxt = 3'd1;
    else if (s == 3'd0 || s == 3'd7)    s_nxt = s;
    else                                s_nxt = s + 3'd1;
  end

  // DBEN/CSEN are registered off the next state so they line up with S itself.
  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) begin
      phi1_reg  <= 1'b0;
      phi0_seen <= 1'b0;
      s         <= 3'd0;
      dben      <= 1'b0;
      csen      <= 1'b0;
      regen     <= 1'b0;
    end else begin
      phi1_reg  <= PHI1;
      phi0_seen <= phi0_seen | ~PHI1;
      s         <= s_nxt;
      dben      <= s_nxt[2];
      csen      <= (s_nxt == 3'd4 && nWE) || (s_nxt >= 3'd5);
      if (s == 3'd5 && !nIOSEL) regen <= 1'b1;
    end

  assign reg_sel  = !nDEVSEL && regen;
  assign data_sel = reg_sel && (A == 4'h3);
  assign wr6      = reg_sel && !nWE && (s == 3'd6);
  assign ptr_wr   = wr6 && (A < 4'h3);
  assign step1    = pend && (s == 3'd1);
  assign stat_clr = reg_sel && nWE && (s == 3'd6) && (A == 4'h5);

  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) begin
      ctrl   <= 4'h0;
      bank_q <= 1'b0;
      pend   <= 1'b0;
      pidx   <= 2'd0;
      pdir   <= 1'b0;
      wrap   <= '0;
    end else begin
      if (wr6 && A == 4'h4) ctrl   <= Din[3:0];
      if (wr6 && A == 4'hF) bank_q <= Din[0];
      // Target is latched here so a later CTRL write cannot redirect the step.
      if (data_sel && s == 3'd6 && ctrl[2]) begin
        pend <= 1'b1;
        pidx <= p;
        pdir <= ctrl[3];
      end else if (step1) begin
        pend <= 1'b0;
      end
      wrap <= (wrap & ~{NPTR{stat_clr}}) | wrap_set;
    end

  for (genvar i = 0; i < NPTR; i++) begin : g_lane
    ramdisk_ptr_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (C7M),
      .rst_n (nRES),
      .wr    (ptr_wr && p == 2'(i)),
      .bsel  (A[1:0]),
      .din   (Din),
      .step  (step1 && pidx == 2'(i)),
      .dir   (pdir),
      .ptr   (ptrs[i]),
      .wrap  (wrap_set[i])
    );
  end

  always_comb begin
    RA = '0;
    for (int i = 0; i < NPTR; i++)
      if (p == 2'(i)) RA = ptrs[i];
  end

  always_comb begin
    rext = '0;
    rext[ADDR_W-1:0] = RA;
    st = '0;
    st[NPTR-1:0] = wrap;
    case (A)
      4'h0:    Dout = rext[7:0];
      4'h1:    Dout = rext[15:8];
      4'h2:    Dout = rext[23:16];
      4'h3:    Dout = RD;
      4'h4:    Dout = {4'h0, ctrl};
      4'h5:    Dout = st;
      default: Dout = 8'h00;
    endcase
  end

  assign RAMCS = data_sel & csen;
  assign RDOE  = dben & ~nWE;
  assign DOE   = dben & nWE & reg_sel;
  assign Bank  = bank_q;
endmodule

// File: tb/tb_ramdisk_ptr_ctrl.sv
// Directed bench for ramdisk_ptr_ctrl: one PHI1-framed bus cycle per access, per-S sampling.
module tb_ramdisk_ptr_ctrl;
  logic        C7M, nRES, PHI1, nWE, nDEVSEL, nIOSEL;
  logic [3:0]  A;
  logic [7:0]  Din, RD, Dout;
  logic        DOE, RDOE, RAMCS, Bank;
  logic [23:0] RA;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rdata, ramcs_v, rdoe_v, doe_v;
  logic [23:0] ra4;

  ramdisk_ptr_ctrl #(.ADDR_W(24), .NPTR(2)) dut (
    .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .A(A), .nWE(nWE), .nDEVSEL(nDEVSEL),
    .nIOSEL(nIOSEL), .Din(Din), .RD(RD), .Dout(Dout), .DOE(DOE), .RDOE(RDOE),
    .RAMCS(RAMCS), .RA(RA), .Bank(Bank)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge C7M);
    @(negedge C7M);
  endtask

  // One bus cycle: PHI1 low then high syncs S to 1; access held S1..S7.
  // abort_s != 0 asserts reset at that S.
  task automatic bus(input logic [3:0] a, input logic wr, input logic [7:0] d,
                     input logic io, input int abort_s);
    logic done;
    done = 1'b0;
    ramcs_v = '0; rdoe_v = '0; doe_v = '0; rdata = '0; ra4 = '0;
    PHI1 = 1'b0; cyc();
    PHI1 = 1'b1; cyc();
    A = a; nWE = ~wr; Din = d; nDEVSEL = io; nIOSEL = ~io;
    for (int k = 1; k <= 7; k++) begin
      if (!done) begin
        if (k > 1) cyc();
        #1;
        ramcs_v[k] = RAMCS;
        rdoe_v[k]  = RDOE;
        doe_v[k]   = DOE;
        if (k == 4) ra4 = RA;
        if (k == 6) rdata = Dout;
        if (k == abort_s) begin
          chk("rst_pre_rdoe", RDOE, 1);
          nRES = 1'b0;
          #1;
          chk("rst_ramcs", RAMCS, 0);
          chk("rst_doe", DOE, 0);
          chk("rst_rdoe", RDOE, 0);
          done = 1'b1;
        end
      end
    end
    if (!done) cyc();
    nDEVSEL = 1'b1; nIOSEL = 1'b1; nWE = 1'b1; A = 4'h0;
    if (done) begin
      cyc();
      nRES = 1'b1;
      cyc();
    end
  endtask

  initial begin
    logic any;
    nRES = 1'b0; PHI1 = 1'b1; A = 4'h0; nWE = 1'b1; nDEVSEL = 1'b1; nIOSEL = 1'b1;
    Din = 8'h00; RD = 8'hA5;
    #1;
    chk("reset_doe", DOE, 0);
    chk("reset_ramcs", RAMCS, 0);
    chk("reset_rdoe", RDOE, 0);
    chk("reset_ra", RA, 0);
    chk("reset_bank", Bank, 0);
    repeat (3) cyc();
    nRES = 1'b1;

    // PHI1 never low: S stays 0, nothing fires
    any = 1'b0;
    nDEVSEL = 1'b0; A = 4'h3;
    repeat (12) begin cyc(); #1; any |= RAMCS | DOE | RDOE; end
    chk("unsync_quiet", any, 0);
    nDEVSEL = 1'b1; A = 4'h0;

    // Register access before Cn00 is ignored
    bus(4'h4, 1, 8'h04, 0, 0);
    chk("dben_window", rdoe_v, 8'hF0);
    chk("noreg_ramcs", ramcs_v, 8'h00);
    bus(4'h4, 0, 8'h00, 0, 0);
    chk("noreg_doe", doe_v, 8'h00);
    bus(4'h0, 0, 8'h00, 1, 0);
    bus(4'h4, 1, 8'h04, 0, 0);
    bus(4'h4, 0, 8'h00, 0, 0);
    chk("ctrl_rd", rdata, 8'h04);
    chk("doe_window", doe_v, 8'hF0);

    // Auto-increment across a 16-bit carry
    bus(4'h0, 1, 8'hFF, 0, 0);
    bus(4'h1, 1, 8'hFF, 0, 0);
    bus(4'h2, 1, 8'h00, 0, 0);
    bus(4'h3, 0, 8'h00, 0, 0);
    chk("inc_ra0", ra4, 24'h00FFFF);
    chk("data_rd", rdata, 8'hA5);
    chk("rd_ramcs", ramcs_v & 8'hEE, 8'hE0);
    bus(4'h3, 0, 8'h00, 0, 0);
    chk("inc_ra1", ra4, 24'h010000);
    bus(4'h3, 0, 8'h00, 0, 0);
    chk("inc_ra2", ra4, 24'h010001);
    bus(4'h5, 0, 8'h00, 0, 0);
    chk("inc_nowrap", rdata, 8'h00);
    bus(4'h0, 0, 8'h00, 0, 0);
    chk("ptr0_b0", rdata, 8'h02);
    bus(4'h2, 0, 8'h00, 0, 0);
    chk("ptr0_b2", rdata, 8'h01);

    // Decrement wrap on pointer 1
    bus(4'h4, 1, 8'h0D, 0, 0);
    bus(4'h0, 1, 8'h00, 0, 0);
    bus(4'h1, 1, 8'h00, 0, 0);
    bus(4'h2, 1, 8'h00, 0, 0);
    bus(4'h3, 1, 8'h5A, 0, 0);
    chk("wr_rdoe", rdoe_v, 8'hF0);
    chk("wr_ramcs", ramcs_v & 8'hDE, 8'hC0);
    bus(4'h5, 0, 8'h00, 0, 0);
    chk("wrap_stat", rdata, 8'h02);
    chk("dec_ra", ra4, 24'hFFFFFF);
    bus(4'h5, 0, 8'h00, 0, 0);
    chk("wrap_clr", rdata, 8'h00);
    bus(4'h1, 0, 8'h00, 0, 0);
    chk("ptr1_b1", rdata, 8'hFF);

    // Pending step keeps its latched index across a CTRL write
    bus(4'h4, 1, 8'h04, 0, 0);
    bus(4'h3, 0, 8'h00, 0, 0);
    bus(4'h4, 1, 8'h05, 0, 0);
    bus(4'h0, 0, 8'h00, 0, 0);
    chk("pend_ptr1", rdata, 8'hFF);
    bus(4'h4, 1, 8'h00, 0, 0);
    bus(4'h0, 0, 8'h00, 0, 0);
    chk("pend_ptr0_b0", rdata, 8'h03);
    bus(4'h2, 0, 8'h00, 0, 0);
    chk("pend_ptr0_b2", rdata, 8'h01);

    // Bank bit and read-zero registers
    bus(4'hF, 1, 8'h01, 0, 0);
    chk("bank_set", Bank, 1);
    bus(4'hF, 0, 8'h00, 0, 0);
    chk("bank_rd0", rdata, 8'h00);
    chk("bank_doe", doe_v, 8'hF0);
    bus(4'h7, 0, 8'h00, 0, 0);
    chk("unmapped_rd", rdata, 8'h00);

    // Reset mid data write, then everything is back to zero
    bus(4'h3, 1, 8'h77, 0, 5);
    chk("post_ra", RA, 0);
    chk("post_bank", Bank, 0);
    bus(4'h4, 0, 8'h00, 0, 0);
    chk("post_regen_off", doe_v, 8'h00);
    bus(4'h0, 0, 8'h00, 1, 0);
    bus(4'h2, 0, 8'h00, 0, 0);
    chk("post_ptr_b2", rdata, 8'h00);
    bus(4'h4, 0, 8'h00, 0, 0);
    chk("post_ctrl", rdata, 8'h00);
    chk("post_doe", doe_v, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
